dm_store_unit: RTL and testbench
================================

Name: dm_store_unit

Overview:
Word-organised data memory for the single-cycle MIPS core. It applies sb/sh/sw byte-lane merging on store and returns the raw 32-bit word on load.
- Sits directly upstream of the load-extension stage. That stage consumes rdata together with the same addr and does the lb/lh lane select and sign extension.
- Writes happen at the clock edge. Reads are combinational.
- Misaligned stores are detected, suppressed and flagged.

Parameters:
- DEPTH_LOG2, 10, log2 of number of 32-bit words (default 1024 words = 4 KiB).
- INIT_ZERO, 1, 1 = async reset clears every word; 0 = reset leaves array contents untouched (flag/counter still reset).

Ports:
- clk  input  1  core clock; all writes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc  input  32  PC of current instruction; used only by trace feature.
- addr  input  32  byte address from ALU.
- wdata  input  32  store data (rt register value).
- we  input  1  memory write enable from control.
- store_type_sel  input  2  01 = sb, 10 = sh, 00/11 = sw. Same encoding as the load-type select.
- rdata  output  32  raw word at addr[DEPTH_LOG2+1:2], combinational.
- align_err  output  1  sticky registered flag: a misaligned store was attempted.
- store_cnt  output  16  count of committed stores, saturating.

Behaviour:
Reset (rst_n low, asynchronous, takes effect immediately):
- align_err = 0 and store_cnt = 0.
- If INIT_ZERO = 1, every word = 0.
- rdata follows array contents (0 after clearing reset).
- Reset asserted mid-store: that store is lost, with no partial write.

Addressing:
- word index = addr[DEPTH_LOG2+1:2].
- Upper address bits are ignored, so addresses wrap modulo 4·2^DEPTH_LOG2 bytes.

Lane generation (combinational):
- sb:
  - byte enable = one-hot on addr[1:0] (00→be 0001 … 11→be 1000).
  - Lane data = wdata[7:0] replicated to all four bytes.
- sh:
  - addr[1] = 0 → be 0011; addr[1] = 1 → be 1100.
  - Lane data = {wdata[15:0], wdata[15:0]}.
- sw: be 1111, lane data = wdata.

Misalignment (combinational):
- sh with addr[0] = 1.
- sw with addr[1:0] ≠ 00.
- sb is never misaligned.

Commit on the rising clk edge, only when we = 1 and the store is aligned:
- Each enabled byte of mem[index] takes the lane byte; disabled bytes keep their value.
- store_cnt increments, saturating at 16'hFFFF.

Misaligned store (we = 1):
- No array change and no counter change.
- align_err sets to 1 on the same edge and stays 1 until reset.

we = 0: no state change, regardless of store_type_sel or alignment.

Read-during-write, same address:
- Before the edge, rdata shows the old word.
- After the edge it shows the merged word; there is no bypass.

Latency:
- Store visible on rdata 1 cycle after issue.
- Load data available in the same cycle.

Optional Feature:
Macro DM_TRACE_EN.
- Defined: on every committed store, simulation prints "@<pc hex8>: *<byte addr hex8> <= <merged word hex8>". The address printed is the word-aligned address ({addr[31:2],2'b00}), matching the course grader format. Misaligned attempts print "@<pc>: misaligned store <addr>". Non-synthesizable code is wrapped in the macro guard.
- Undefined: no trace code is compiled. Behaviour is otherwise identical.

Decomposition:
Shared package/header holds:
- STORE_W = 2'b00, STORE_B = 2'b01, STORE_H = 2'b10. These constants are shared with the load-type select so both stages decode identically.
- Byte-enable width constant (4).

Sub-module store_lane_gen (purely combinational):
- Inputs: addr[1:0], store_type_sel, wdata.
- Outputs: be[3:0], lane_data[31:0], misaligned.
- The top module holds the array, align_err, store_cnt and the trace.

Test Plan:
1. Reset → rdata = 0 at addr 0x0 and 0xFFC; align_err = 0; store_cnt = 0.
2. sw 0x12345678 @0x10; then sb wdata = 0xAB @0x11 → read @0x10 = 0x1234AB78; store_cnt = 2.
3. sh wdata = 0x0000BEEF @0x22 onto word previously 0x11223344 → 0xBEEF3344. Then sh 0xCAFE @0x20 → 0xBEEFCAFE.
4. sw 0xDEADBEEF @0x31 and sh @0x23 → word @0x30 and word @0x20 unchanged; align_err = 1 from the first edge; store_cnt unchanged. A later aligned sw still commits and align_err stays 1.
5. we = 0 with sb @0x40 and wdata 0xFF → no change. sw @0x1004 with DEPTH_LOG2 = 10 → lands in word 1 (wrap), read @0x4 = written value.
6. Assert rst_n low mid-cycle between two stores → outputs clear immediately; subsequent reads = 0 (INIT_ZERO = 1).

Source files
------------

// File: rtl/dm_store_unit_pkg.sv
// dm_store_unit_pkg: store/load type encodings and byte-enable width shared by the memory stages
package dm_store_unit_pkg;
  localparam logic [1:0] STORE_W = 2'b00;
  localparam logic [1:0] STORE_B = 2'b01;
  localparam logic [1:0] STORE_H = 2'b10;
  localparam int BE_W = 4;
endpackage

// File: rtl/dm_store_unit_if.sv
// dm_store_unit_if: core<->data-memory bus (pc, addr, wdata, we, store_type_sel in; rdata, align_err, store_cnt out)
interface dm_store_unit_if;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [1:0]  store_type_sel;
  logic [31:0] rdata;
  logic        align_err;
  logic [15:0] store_cnt;
  modport master (output pc, addr, wdata, we, store_type_sel, input rdata, align_err, store_cnt);
  modport slave (input pc, addr, wdata, we, store_type_sel, output rdata, align_err, store_cnt);
endinterface

// File: rtl/dm_store_unit_store_lane_gen.sv
// store_lane_gen: sb/sh/sw byte enables, replicated lane data and misalignment from addr_lo, store_type_sel, wdata
module store_lane_gen
  import dm_store_unit_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      store_type_sel,
  input  logic [31:0]     wdata,
  output logic [BE_W-1:0] be,
  output logic [31:0]     lane_data,
  output logic            misaligned
);
  always_comb begin
    be = store_type_sel == STORE_B ? 4'b0001 << addr_lo :
         store_type_sel == STORE_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    lane_data = store_type_sel == STORE_B ? {4{wdata[7:0]}} :
                store_type_sel == STORE_H ? {2{wdata[15:0]}} : wdata;
    misaligned = store_type_sel == STORE_B ? 1'b0 :
                 store_type_sel == STORE_H ? addr_lo[0] : |addr_lo;
  end
endmodule

// File: rtl/dm_store_unit.sv
// dm_store_unit: word data memory with sb/sh/sw merge, combinational read, sticky align_err, saturating store_cnt; clk, rst_n, bus(slave); DM_TRACE_EN enables store trace
module dm_store_unit
  import dm_store_unit_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter bit INIT_ZERO  = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  dm_store_unit_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [BE_W-1:0]       be;
  logic [31:0]           lane_data;
  logic [31:0]           rdata;
  logic [31:0]           merged;
  logic                  misaligned;
  logic                  commit;
  logic                  align_err;
  logic [15:0]           store_cnt;
  logic                  unused;
  store_lane_gen u_lane (
    .addr_lo       (bus.addr[1:0]),
    .store_type_sel(bus.store_type_sel),
    .wdata         (bus.wdata),
    .be            (be),
    .lane_data     (lane_data),
    .misaligned    (misaligned)
  );
  assign idx    = bus.addr[DEPTH_LOG2+1:2];
  assign rdata  = mem[idx];
  assign commit = bus.we & ~misaligned;
  assign unused = ^{bus.pc, bus.addr[31:DEPTH_LOG2+2]};
  always_comb begin
    merged = rdata;
    for (int b = 0; b < BE_W; b++) merged[8*b +: 8] = be[b] ? lane_data[8*b +: 8] : rdata[8*b +: 8];
  end
  if (INIT_ZERO) begin : g_clr
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else if (commit)
        mem[idx] <= merged;
  end else begin : g_keep
    always_ff @(posedge clk)
      if (rst_n && commit) mem[idx] <= merged;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      align_err <= 1'b0;
      store_cnt <= '0;
    end else begin
      if (bus.we && misaligned) align_err <= 1'b1;
      if (commit && store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
    end
  assign bus.rdata     = rdata;
  assign bus.align_err = align_err;
  assign bus.store_cnt = store_cnt;
`ifdef DM_TRACE_EN
  always @(posedge clk)
    if (rst_n && bus.we)
      if (misaligned) $display("@%08h: misaligned store %08h", bus.pc, bus.addr);
      else $display("@%08h: *%08h <= %08h", bus.pc, {bus.addr[31:2], 2'b00}, merged);
`else
`endif
endmodule

// File: tb/tb_dm_store_unit.sv
// tb_dm_store_unit: byte-addressed reference model plus directed literal checks and randomized stores
module tb_dm_store_unit;
  import dm_store_unit_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_sz;
  logic [7:0]  mb [4096];
  logic        m_err;
  logic [15:0] m_cnt;
  logic [31:0] pc_ctr = 32'h0040_0000;
  logic [31:0] ra;
  dm_store_unit_if bus ();
  dm_store_unit #(.DEPTH_LOG2(10), .INIT_ZERO(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [31:0] mword(input logic [31:0] a);
    int base = int'({a[11:2], 2'b00});
    return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      foreach (mb[i]) mb[i] = 8'h00;
      m_err = 1'b0;
      m_cnt = 16'h0;
    end else if (bus.we) begin
      m_sz = bus.store_type_sel == STORE_B ? 1 : bus.store_type_sel == STORE_H ? 2 : 4;
      if (bus.addr % m_sz != 0) m_err = 1'b1;
      else begin
        for (int k = 0; k < m_sz; k++) mb[int'(bus.addr % 4096) + k] = bus.wdata[8*k +: 8];
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    check("model_rdata", bus.rdata, mword(bus.addr));
    check("model_align_err", {31'd0, bus.align_err}, {31'd0, m_err});
    check("model_store_cnt", {16'd0, bus.store_cnt}, {16'd0, m_cnt});
  end
  task automatic op(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    bus.we = w;
    bus.store_type_sel = s;
    bus.addr = a;
    bus.wdata = d;
    bus.pc = pc_ctr;
    pc_ctr += 4;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask
  initial begin
    bus.we = 1'b0;
    bus.store_type_sel = STORE_W;
    bus.addr = '0;
    bus.wdata = '0;
    bus.pc = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(32'h0, ra); check("reset_rd0", ra, 32'h0);
    rd(32'hFFC, ra); check("reset_rdffc", ra, 32'h0);
    check("reset_align", {31'd0, bus.align_err}, 32'd0);
    check("reset_cnt", {16'd0, bus.store_cnt}, 32'd0);
    op(1'b1, STORE_W, 32'h10, 32'h1234_5678);
    op(1'b1, STORE_B, 32'h11, 32'h0000_00AB);
    rd(32'h10, ra); check("sb_merge", ra, 32'h1234_AB78);
    check("cnt_after_2", {16'd0, bus.store_cnt}, 32'd2);
    op(1'b1, STORE_W, 32'h20, 32'h1122_3344);
    op(1'b1, STORE_H, 32'h22, 32'h0000_BEEF);
    rd(32'h20, ra); check("sh_upper", ra, 32'hBEEF_3344);
    op(1'b1, STORE_H, 32'h20, 32'h0000_CAFE);
    rd(32'h20, ra); check("sh_lower", ra, 32'hBEEF_CAFE);
    op(1'b1, STORE_W, 32'h31, 32'hDEAD_BEEF);
    check("misalign_sets", {31'd0, bus.align_err}, 32'd1);
    rd(32'h30, ra); check("misalign_sw_nowrite", ra, 32'h0);
    op(1'b1, STORE_H, 32'h23, 32'h0000_5555);
    rd(32'h20, ra); check("misalign_sh_nowrite", ra, 32'hBEEF_CAFE);
    check("misalign_cnt", {16'd0, bus.store_cnt}, 32'd5);
    op(1'b1, STORE_W, 32'h30, 32'h600D_F00D);
    rd(32'h30, ra); check("aligned_after_err", ra, 32'h600D_F00D);
    check("align_sticky", {31'd0, bus.align_err}, 32'd1);
    op(1'b0, STORE_B, 32'h40, 32'h0000_00FF);
    rd(32'h40, ra); check("we0_nochange", ra, 32'h0);
    check("we0_cnt", {16'd0, bus.store_cnt}, 32'd6);
    op(1'b1, STORE_W, 32'h1004, 32'hA5A5_5A5A);
    rd(32'h4, ra); check("wrap", ra, 32'hA5A5_5A5A);
    bus.we = 1'b1;
    bus.store_type_sel = STORE_W;
    bus.addr = 32'h44;
    bus.wdata = 32'h0BAD_CAFE;
    #1 check("rdw_old", bus.rdata, 32'h0);
    @(posedge clk);
    #1 check("rdw_new", bus.rdata, 32'h0BAD_CAFE);
    check("cnt_after_rdw", {16'd0, bus.store_cnt}, 32'd8);
    bus.addr = 32'h10;
    bus.wdata = 32'hFFFF_FFFF;
    #2 rst_n = 1'b0;
    #1 check("midrst_align", {31'd0, bus.align_err}, 32'd0);
    check("midrst_cnt", {16'd0, bus.store_cnt}, 32'd0);
    check("midrst_rdata", bus.rdata, 32'h0);
    @(posedge clk);
    #1 check("midrst_lost", bus.rdata, 32'h0);
    bus.we = 1'b0;
    rst_n = 1'b1;
    rd(32'h10, ra); check("post_rst_10", ra, 32'h0);
    rd(32'h4, ra); check("post_rst_4", ra, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [1:0] s;
      a = $urandom;
      a[11:2] = 10'($urandom_range(0, 15));
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) != 0) a[1:0] = s == STORE_B ? a[1:0] : s == STORE_H ? {a[1], 1'b0} : 2'b00;
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      op($urandom_range(0, 3) != 0, s, a, $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
